chunk_scanner: RTL and testbench
================================

Name: chunk_scanner

Overview:
- Frame-level sequencer that sits in front of chunk_drawer and acts as its initiator.
- Walks every chunk of the 640x480 display in raster order, 40x30 chunks of 16x16 pixels.
- For each chunk: reads its 2-bit state from the board RAM, presents chunk coordinates and state to chunk_drawer, restarts the drawer, and gates its pixel stream with a write enable until the drawer reports done.
- One start pulse repaints the whole frame.

Parameters:
- CHUNK_SIZE, 16: pixels per chunk side. Must match chunk_drawer.
- COLS, 40: chunks per row.
- ROWS, 30: chunks per column.
- ADDR_W, 11: board RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to repaint the frame; sampled only in IDLE.
- mem_addr  out  ADDR_W  board RAM read address.
- mem_data  in  2  board RAM read data; synchronous RAM, valid the cycle after the address is presented.
- x_chunk  out  6  current chunk column, to chunk_drawer.
- y_chunk  out  5  current chunk row, to chunk_drawer.
- data_out  out  2  latched chunk state, to chunk_drawer data_in.
- drawer_reset  out  1  active-high synchronous restart for chunk_drawer.
- drawer_done  in  1  chunk_drawer done.
- pixel_we  out  1  framebuffer write enable, qualifying the drawer's x/y/r/g/b.
- busy  out  1  high from leaving IDLE until return to IDLE.
- frame_done  out  1  one-cycle pulse when the last chunk completes.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; x_chunk = 0; y_chunk = 0; data_out = 0.
  - drawer_reset = 1; pixel_we = 0; busy = 0; frame_done = 0.
- mem_addr is combinational: y_chunk*COLS + x_chunk, zero-extended to ADDR_W. Maximum value is 1199.
- States:
  - IDLE:
    - drawer_reset = 1, busy = 0.
    - start = 1 -> clear x_chunk and y_chunk to 0, go to READ.
  - READ:
    - Address presented, busy = 1, drawer_reset = 1.
    - Next state WAIT_MEM.
  - WAIT_MEM:
    - mem_data is valid this cycle; data_out <= mem_data at the edge.
    - Next state CLEAR.
  - CLEAR:
    - drawer_reset = 1 for exactly this cycle, clearing the drawer counters and done.
    - Next state DRAW.
  - DRAW:
    - drawer_reset = 0.
    - pixel_we = 0 on the first DRAW cycle, because the drawer's registered x/y still hold reset values.
    - pixel_we = 1 on every later DRAW cycle, including the cycle where drawer_done = 1.
    - Exactly 256 enabled cycles per chunk; drawer_done is seen on the 257th DRAW cycle.
    - drawer_done = 1 on the first DRAW cycle is ignored; it cannot occur after CLEAR, and the bench must flag it if it does.
    - On drawer_done -> NEXT.
  - NEXT:
    - pixel_we = 0, drawer_reset = 1.
    - If x_chunk < COLS-1: x_chunk + 1, go to READ.
    - Else if y_chunk < ROWS-1: x_chunk = 0, y_chunk + 1, go to READ.
    - Else (chunk 39,29): pulse frame_done = 1 for one cycle, x_chunk = 0, y_chunk = 0, go to IDLE.
- Timing: 261 cycles per chunk (READ 1, WAIT_MEM 1, CLEAR 1, DRAW 257, NEXT 1); 313200 cycles per frame from start to frame_done.
- x_chunk, y_chunk and data_out are stable from CLEAR through NEXT.
- start outside IDLE is ignored, with no queuing.
- start in the same cycle frame_done pulses is ignored: the state is NEXT, not IDLE.
- Reset asserted mid-frame aborts immediately to the reset values; the next start begins again at chunk (0,0).
- drawer_done stuck low stalls in DRAW indefinitely with pixel_we = 1. There is no timeout.

Test Plan:
- Reset low, then high, no start -> IDLE; busy = 0, drawer_reset = 1, pixel_we = 0, mem_addr = 0, held for 100 cycles.
- Single start, RAM chunk 0 = 2'b10, drawer model attached:
  - mem_addr = 0 in READ; data_out = 2'b10 from CLEAR.
  - drawer_reset high for 1 cycle; pixel_we high for exactly 256 cycles.
  - First enabled pixel is x=0, y=0; last is x=15, y=15; next READ has mem_addr = 1.
- Row wrap: at chunk (39,0) completion -> x_chunk = 0, y_chunk = 1, mem_addr = 40. Chunk (0,1) draws pixel origin x=0, y=16.
- Full frame with RAM pattern addr[1:0]:
  - frame_done pulses once at cycle 313200 after start; busy then falls.
  - 1200 chunks and 307200 write enables counted.
  - Each chunk's data_out matches the RAM contents.
- start pulsed mid-DRAW and again coincident with frame_done -> no effect: chunk order and counts unchanged, returns to IDLE.
- Reset low during DRAW of chunk (5,2) -> outputs take reset values within the same cycle. Subsequent start restarts at mem_addr = 0.

Source files
------------

// File: rtl/chunk_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_scanner
//  Purpose  : Frame-level sequencer that drives chunk_drawer. Walks every
//             chunk of the display in raster order, fetches each chunk's
//             2-bit state from board RAM and restarts the drawer. It also
//             gates the drawer's pixel stream with a write enable until the
//             drawer reports done. One start pulse repaints the whole frame.
//  Ports    : clk          - system clock, rising edge
//             reset        - asynchronous active-low reset
//             start        - one-cycle repaint request (honoured in IDLE only)
//             mem_addr     - board RAM read address (combinational)
//             mem_data     - board RAM read data (one-cycle read latency)
//             x_chunk      - current chunk column
//             y_chunk      - current chunk row
//             data_out     - latched chunk state for chunk_drawer
//             drawer_reset - synchronous active-high restart for the drawer
//             drawer_done  - drawer has finished the current chunk
//             pixel_we     - framebuffer write enable for the drawer's pixels
//             busy         - frame in progress
//             frame_done   - one-cycle pulse when the last chunk completes
//  Revision : 1.0 - initial release
// ============================================================================
module chunk_scanner #(
  parameter int CHUNK_SIZE = 16,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic [5:0]        x_chunk,
  output logic [4:0]        y_chunk,
  output logic [1:0]        data_out,
  output logic              drawer_reset,
  input  logic              drawer_done,
  output logic              pixel_we,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_CLEAR    = 3'd3;
  localparam logic [2:0] S_DRAW     = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  localparam logic [5:0] C_LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

  // Elaboration-time guard: the chunk grid must fit the coordinate ports
  // and the board RAM address space, and the chunk must be non-empty.
  if (CHUNK_SIZE < 1 || COLS < 1 || ROWS < 1 || COLS > 64 || ROWS > 32 ||
      (COLS * ROWS) > (1 << ADDR_W)) begin : g_bad_params
    $error("chunk_scanner: illegal parameter combination");
  end

  logic [2:0] state_q, state_d;
  logic [5:0] x_chunk_q, x_chunk_d;
  logic [4:0] y_chunk_q, y_chunk_d;
  logic [1:0] data_q, data_d;
  // Marks the first DRAW cycle: the drawer's registered pixel outputs still
  // hold their reset values then, so that cycle is never written.
  logic       first_draw_q, first_draw_d;
  logic       last_chunk;

  assign last_chunk = (x_chunk_q == C_LAST_COL) && (y_chunk_q == C_LAST_ROW);

  always_comb begin
    state_d      = state_q;
    x_chunk_d    = x_chunk_q;
    y_chunk_d    = y_chunk_q;
    data_d       = data_q;
    first_draw_d = first_draw_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_chunk_d = 6'd0;
          y_chunk_d = 5'd0;
          state_d   = S_READ;
        end
      end
      S_READ:     state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        data_d  = mem_data;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        first_draw_d = 1'b1;
        state_d      = S_DRAW;
      end
      S_DRAW: begin
        first_draw_d = 1'b0;
        // A done seen on the first DRAW cycle is stale and is ignored.
        if (drawer_done && !first_draw_q) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (x_chunk_q < C_LAST_COL) begin
          x_chunk_d = x_chunk_q + 6'd1;
          state_d   = S_READ;
        end else if (y_chunk_q < C_LAST_ROW) begin
          x_chunk_d = 6'd0;
          y_chunk_d = y_chunk_q + 5'd1;
          state_d   = S_READ;
        end else begin
          x_chunk_d = 6'd0;
          y_chunk_d = 5'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x_chunk_q    <= 6'd0;
      y_chunk_q    <= 5'd0;
      data_q       <= 2'd0;
      first_draw_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_chunk_q    <= x_chunk_d;
      y_chunk_q    <= y_chunk_d;
      data_q       <= data_d;
      first_draw_q <= first_draw_d;
    end
  end

  assign mem_addr     = ADDR_W'(y_chunk_q) * ADDR_W'(COLS) + ADDR_W'(x_chunk_q);
  assign x_chunk      = x_chunk_q;
  assign y_chunk      = y_chunk_q;
  assign data_out     = data_q;
  // The drawer is held in restart in every state except DRAW.
  assign drawer_reset = (state_q != S_DRAW);
  assign pixel_we     = (state_q == S_DRAW) && !first_draw_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_NEXT) && last_chunk;

endmodule
`default_nettype wire

// File: tb/tb_chunk_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chunk_scanner
//  Purpose  : Self-checking bench for chunk_scanner with a board RAM model
//             and a chunk_drawer model. Expected chunk order and contents go
//             to a scoreboard when a frame is started and are compared as
//             each chunk's first enabled pixel appears. The grid is kept at
//             40 columns so the row wrap is exercised at its real point, with
//             3 rows to keep frame length short.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chunk_scanner;

  localparam int COLS      = 40;
  localparam int ROWS      = 3;
  localparam int ADDR_W    = 11;
  localparam int CHUNK_CYC = 261;
  localparam int FRAME_CYC = COLS * ROWS * CHUNK_CYC;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;
  logic [5:0]        x_chunk;
  logic [4:0]        y_chunk;
  logic [1:0]        data_out;
  logic              drawer_reset;
  logic              drawer_done;
  logic              pixel_we;
  logic              busy;
  logic              frame_done;

  chunk_scanner #(
    .CHUNK_SIZE(16), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .x_chunk(x_chunk), .y_chunk(y_chunk), .data_out(data_out),
    .drawer_reset(drawer_reset), .drawer_done(drawer_done),
    .pixel_we(pixel_we), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous board RAM: data valid the cycle after the address.
  logic [1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) mem_data <= ram[mem_addr];

  // chunk_drawer model: registered pixel coordinates, 256 pixels per chunk,
  // done raised together with the last pixel.
  logic [8:0] dcnt;
  logic [9:0] px;
  logic [8:0] py;
  always @(posedge clk) begin
    if (drawer_reset) begin
      dcnt        <= 9'd0;
      drawer_done <= 1'b0;
      px          <= 10'd0;
      py          <= 9'd0;
    end else if (dcnt < 9'd256) begin
      px          <= {x_chunk, 4'b0000} + 10'(dcnt[3:0]);
      py          <= {y_chunk, 4'b0000} + 9'(dcnt[7:4]);
      dcnt        <= dcnt + 9'd1;
      drawer_done <= (dcnt == 9'd255);
    end
  end

  typedef struct {
    int x;
    int y;
    logic [1:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cycle = 0;
  int we_total = 0;
  int chunk_total = 0;
  int chunk_we = 0;
  bit mon_en = 1'b0;
  bit prev_dr = 1'b1;

  // Stream monitor: first-DRAW rules, scoreboard, per-chunk pixel counts.
  always @(negedge clk) begin
    if (!reset) begin
      prev_dr  = 1'b1;
      chunk_we = 0;
    end else if (mon_en) begin
      cyc++;
      if (frame_done) begin
        fd_count++;
        fd_cycle = cyc;
      end
      if (prev_dr && !drawer_reset) begin
        n_total++;
        if (pixel_we !== 1'b0 || drawer_done !== 1'b0)
          $display("FAIL first_draw: pixel_we=%b drawer_done=%b, required 0 0", pixel_we, drawer_done);
        else n_pass++;
      end
      if (pixel_we === 1'b1) begin
        we_total++;
        chunk_we++;
        if (chunk_we == 1) begin
          n_total++;
          if (sb.size() == 0) begin
            $display("FAIL sb_order: chunk (%0d,%0d) drawn but none expected", x_chunk, y_chunk);
          end else begin
            cur = sb.pop_front();
            if (int'(x_chunk) !== cur.x || int'(y_chunk) !== cur.y || data_out !== cur.d ||
                int'(mem_addr) !== cur.y * COLS + cur.x ||
                int'(px) !== cur.x * 16 || int'(py) !== cur.y * 16)
              $display("FAIL sb_chunk: got x=%0d y=%0d d=%0d addr=%0d px=%0d py=%0d, required x=%0d y=%0d d=%0d addr=%0d px=%0d py=%0d",
                       x_chunk, y_chunk, data_out, mem_addr, px, py,
                       cur.x, cur.y, cur.d, cur.y * COLS + cur.x, cur.x * 16, cur.y * 16);
            else n_pass++;
          end
        end
        if (drawer_done === 1'b1) begin
          chunk_total++;
          n_total++;
          if (chunk_we !== 256 || int'(px) !== cur.x * 16 + 15 || int'(py) !== cur.y * 16 + 15)
            $display("FAIL chunk_end: we=%0d px=%0d py=%0d, required 256 %0d %0d",
                     chunk_we, px, py, cur.x * 16 + 15, cur.y * 16 + 15);
          else n_pass++;
          chunk_we = 0;
        end
      end
      prev_dr = drawer_reset;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        e.x = x;
        e.y = y;
        e.d = ram[y * COLS + x];
        sb.push_back(e);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    n_total++;
    if (busy !== 1'b0 || drawer_reset !== 1'b1 || pixel_we !== 1'b0 || frame_done !== 1'b0 ||
        x_chunk !== 6'd0 || y_chunk !== 5'd0 || data_out !== 2'd0)
      $display("FAIL reset_values: busy=%b dr=%b we=%b fd=%b x=%0d y=%0d d=%0d, required 0 1 0 0 0 0 0",
               busy, drawer_reset, pixel_we, frame_done, x_chunk, y_chunk, data_out);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0 || drawer_reset !== 1'b1 || pixel_we !== 1'b0 || mem_addr !== '0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_chunk();
    int we_n = 0;
    push_frame();
    mon_en = 1'b1;
    pulse_start();
    // cycle 1 READ, 2 WAIT_MEM, 3 CLEAR, 4 first DRAW, 5..260 enabled, 261 NEXT
    for (int c = 1; c <= 262; c++) begin
      if (c == 1) begin
        n_total++;
        if (mem_addr !== '0 || busy !== 1'b1 || drawer_reset !== 1'b1)
          $display("FAIL read_state: addr=%0d busy=%b dr=%b, required 0 1 1", mem_addr, busy, drawer_reset);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (data_out !== 2'b10 || drawer_reset !== 1'b1)
          $display("FAIL clear_state: data_out=%b dr=%b, required 10 1", data_out, drawer_reset);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if (drawer_reset !== 1'b0 || pixel_we !== 1'b0)
          $display("FAIL draw_first: dr=%b we=%b, required 0 0", drawer_reset, pixel_we);
        else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if (px !== 10'd0 || py !== 9'd0)
          $display("FAIL first_pixel: x=%0d y=%0d, required 0 0", px, py);
        else n_pass++;
      end
      if (c == 260) begin
        n_total++;
        if (px !== 10'd15 || py !== 9'd15 || drawer_done !== 1'b1 || pixel_we !== 1'b1)
          $display("FAIL last_pixel: x=%0d y=%0d done=%b we=%b, required 15 15 1 1", px, py, drawer_done, pixel_we);
        else n_pass++;
      end
      if (c == 261) begin
        n_total++;
        if (pixel_we !== 1'b0 || drawer_reset !== 1'b1 || we_n !== 256)
          $display("FAIL next_state: we=%b dr=%b enables=%0d, required 0 1 256", pixel_we, drawer_reset, we_n);
        else n_pass++;
      end
      if (c == 262) begin
        n_total++;
        if (mem_addr !== 11'd1 || x_chunk !== 6'd1)
          $display("FAIL second_read: addr=%0d x=%0d, required 1 1", mem_addr, x_chunk);
        else n_pass++;
      end
      if (pixel_we === 1'b1) we_n++;
      if (c < 262) tick();
    end
  endtask

  task automatic test_start_mid_draw();
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (pixel_we === 1'b1 && x_chunk == 6'd1 && dcnt == 9'd100) hit = 1'b1;
    end
    n_total++;
    if (!hit) $display("FAIL mid_draw_wait: DRAW of chunk 1 not reached, required within 400 cycles");
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++;
    if (x_chunk !== 6'd1 || y_chunk !== 5'd0 || pixel_we !== 1'b1)
      $display("FAIL mid_draw_start: x=%0d y=%0d we=%b, required 1 0 1", x_chunk, y_chunk, pixel_we);
    else n_pass++;
  endtask

  task automatic test_row_wrap();
    bit hit = 1'b0;
    for (int i = 0; i < 45 * CHUNK_CYC && !hit; i++) begin
      tick();
      if (drawer_done === 1'b1 && pixel_we === 1'b1 && x_chunk == 6'd39 && y_chunk == 5'd0) hit = 1'b1;
    end
    n_total++;
    if (!hit) $display("FAIL wrap_wait: chunk (39,0) never completed, required within budget");
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (x_chunk !== 6'd0 || y_chunk !== 5'd1 || mem_addr !== 11'd40)
      $display("FAIL row_wrap: x=%0d y=%0d addr=%0d, required 0 1 40", x_chunk, y_chunk, mem_addr);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if (pixel_we !== 1'b1 || px !== 10'd0 || py !== 9'd16)
      $display("FAIL wrap_origin: we=%b x=%0d y=%0d, required 1 0 16", pixel_we, px, py);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    bit hit = 1'b0;
    int bad = 0;
    for (int i = 0; i < FRAME_CYC + 1000 && !hit; i++) begin
      tick();
      if (frame_done === 1'b1) hit = 1'b1;
    end
    n_total++;
    if (!hit || cyc !== FRAME_CYC)
      $display("FAIL frame_time: frame_done seen=%0d at cycle %0d, required 1 at %0d", hit, cyc, FRAME_CYC);
    else n_pass++;
    start = 1'b1;  // coincident with frame_done: must be ignored
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || drawer_reset !== 1'b1 || mem_addr !== '0) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL frame_idle: %0d bad cycles after frame, required 0", bad);
    else n_pass++;
    n_total++;
    if (fd_count !== 1 || chunk_total !== COLS * ROWS || we_total !== COLS * ROWS * 256 || sb.size() !== 0)
      $display("FAIL frame_counts: fd=%0d chunks=%0d we=%0d left=%0d, required 1 %0d %0d 0",
               fd_count, chunk_total, we_total, sb.size(), COLS * ROWS, COLS * ROWS * 256);
    else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    bit hit = 1'b0;
    sb.delete();
    push_frame();
    pulse_start();
    for (int i = 0; i < 90 * CHUNK_CYC && !hit; i++) begin
      tick();
      if (pixel_we === 1'b1 && x_chunk == 6'd5 && y_chunk == 5'd2 && dcnt == 9'd50) hit = 1'b1;
    end
    n_total++;
    if (!hit) $display("FAIL abort_wait: DRAW of chunk (5,2) not reached, required within budget");
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || drawer_reset !== 1'b1 || pixel_we !== 1'b0 || frame_done !== 1'b0 ||
        x_chunk !== 6'd0 || y_chunk !== 5'd0 || data_out !== 2'd0 || mem_addr !== '0)
      $display("FAIL abort_values: busy=%b dr=%b we=%b fd=%b x=%0d y=%0d d=%0d addr=%0d, required 0 1 0 0 0 0 0 0",
               busy, drawer_reset, pixel_we, frame_done, x_chunk, y_chunk, data_out, mem_addr);
    else n_pass++;
    tick();
    reset = 1'b1;
    tick();
    sb.delete();
    push_frame();
    pulse_start();
    n_total++;
    if (mem_addr !== '0 || busy !== 1'b1 || x_chunk !== 6'd0 || y_chunk !== 5'd0)
      $display("FAIL restart: addr=%0d busy=%b x=%0d y=%0d, required 0 1 0 0", mem_addr, busy, x_chunk, y_chunk);
    else n_pass++;
    for (int i = 0; i < 6; i++) tick();
    n_total++;
    if (sb.size() !== COLS * ROWS - 1 || data_out !== 2'b10)
      $display("FAIL restart_chunk: left=%0d d=%b, required %0d 10", sb.size(), data_out, COLS * ROWS - 1);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(i);
      ram[i] = a[1:0];
    end
    ram[0] = 2'b10;
    test_reset();
    test_single_chunk();
    test_start_mid_draw();
    test_row_wrap();
    test_full_frame();
    test_reset_mid_draw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
